// File: rtl/hazard_unit.sv
// hazard_unit: central stall/flush controller for the five-stage pipeline.
// Produces PC/pipeline-register enables and flushes from cache handshakes,
// load-use detection, branch/jump resolution and halt. It also keeps halt
// state, stall/flush performance counters and a sticky data-memory timeout.
module hazard_unit #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        exmem_dmem_req,
  input  logic        exmem_branch_taken,
  input  logic        exmem_halt,
  input  logic        idex_MemRead,
  input  logic [4:0]  idex_rt,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        ifid_uses_rt,
  input  logic        id_jump,
  output logic        pc_WEN,
  output logic        ifid_WEN,
  output logic        idex_WEN,
  output logic        exmem_WEN,
  output logic        memwb_WEN,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic        halt_out,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  // Wait counter only has to reach TIMEOUT_CYCLES-1; it saturates there.
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALTED  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          timeout_q, timeout_d;
  logic [31:0]   stall_q, stall_d;
  logic [31:0]   flush_cnt_q, flush_cnt_d;

  logic          freeze;
  logic          load_use;
  logic          flush_evt;

  // Hazard detection terms shared by the control decode.
  always_comb begin
    freeze   = exmem_dmem_req && !dhit;
    load_use = idex_MemRead && (idex_rt != 5'd0) &&
               ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
  end

  // Next-state and enable/flush decode, priority ordered; reset forces flush.
  always_comb begin
    pc_WEN      = 1'b0;
    ifid_WEN    = 1'b0;
    idex_WEN    = 1'b0;
    exmem_WEN   = 1'b0;
    memwb_WEN   = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    flush_evt   = 1'b0;
    state_d     = state_q;

    if (!nRST) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
      state_d     = RUN;
    end else if (state_q == HALTED) begin
      state_d = HALTED;
    end else if (freeze) begin
      state_d = MEMWAIT;
    end else if (exmem_halt) begin
      // Let the halt itself drain into WB while everything else holds.
      memwb_WEN = 1'b1;
      state_d   = HALTED;
    end else begin
      state_d   = RUN;
      pc_WEN    = 1'b1;
      ifid_WEN  = 1'b1;
      idex_WEN  = 1'b1;
      exmem_WEN = 1'b1;
      memwb_WEN = 1'b1;
      if (exmem_branch_taken) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        flush_evt   = 1'b1;
      end else if (load_use) begin
        // Hold PC and IF/ID, push a bubble into ID/EX.
        pc_WEN     = 1'b0;
        ifid_WEN   = 1'b0;
        idex_flush = 1'b1;
      end else if (id_jump) begin
        pc_WEN     = ihit;
        ifid_flush = 1'b1;
        flush_evt  = ihit;
      end else if (!ihit) begin
        pc_WEN     = 1'b0;
        ifid_flush = 1'b1;
      end
    end
  end

  // Counter and timeout next-state.
  always_comb begin
    stall_d     = stall_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = '0;
    timeout_d   = timeout_q;

    if (!pc_WEN && (state_q != HALTED)) begin
      stall_d = stall_q + 32'd1;
    end
    if (flush_evt) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
    if ((state_q == MEMWAIT) && (state_d == MEMWAIT)) begin
      wait_cnt_d = (wait_cnt_q == WAIT_LAST) ? wait_cnt_q : wait_cnt_q + CW'(1);
    end
    if ((state_q == MEMWAIT) && freeze && (wait_cnt_q == WAIT_LAST)) begin
      timeout_d = 1'b1;
    end
  end

  // State and counter registers with asynchronous clear.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_q     <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_q     <= stall_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign halt_out     = (state_q == HALTED);
  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_q;
  assign flush_events = flush_cnt_q;

endmodule
